// File: rtl/fc_tile_sequencer.sv
// fc_tile_sequencer
//   Job-level controller for the tiled fully-connected datapath. A job loads
//   one IFM vector into the buffer, then for each of NUM_TILES tiles replays
//   the buffer through the PE array, waits out the PE pipeline, captures the
//   psums and serialises the TILING_SIZE outputs over a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start / busy / done host job interface (start sampled only in IDLE)
//   ifm_valid, ifm_read IFM word handshake during LOAD
//   buf_wr_en/rd_en     IFM buffer write / read strobes
//   buf_wr_clr/rd_clr   IFM buffer pointer clears
//   wgt_read            pop one TILING_SIZE-wide weight word
//   set_reg, psum_clr   PE accumulate enable / zero psum_in on first step
//   set_output          load capture registers from psum_out
//   out_sel, valid_data output mux select and valid toward downstream
//   out_ready           downstream accepts the selected output
//   tile_idx, acc_idx   current tile / position within LOAD or COMPUTE
module fc_tile_sequencer #(
  parameter int unsigned IFM_SIZE    = 9162,
  parameter int unsigned KERNEL_SIZE = 4096,
  parameter int unsigned TILING_SIZE = 8,
  parameter int unsigned PIPE_LAT    = 1,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned SEL_W      = $clog2(TILING_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 ifm_valid,
  output logic                 ifm_read,
  output logic                 buf_wr_en,
  output logic                 buf_rd_en,
  output logic                 buf_wr_clr,
  output logic                 buf_rd_clr,
  output logic                 wgt_read,
  output logic                 set_reg,
  output logic                 psum_clr,
  output logic                 set_output,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 valid_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] tile_idx,
  output logic [CNT_WIDTH-1:0] acc_idx
);

  localparam int unsigned NUM_TILES = KERNEL_SIZE / TILING_SIZE;
  localparam int unsigned FL_W      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CNT_WIDTH-1:0] ACC_LAST  = CNT_WIDTH'(IFM_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] TILE_LAST = CNT_WIDTH'(NUM_TILES - 1);
  localparam logic [SEL_W-1:0]     SEL_LAST  = SEL_W'(TILING_SIZE - 1);
  localparam logic [FL_W-1:0]      FL_LAST   = FL_W'(PIPE_LAT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_FLUSH   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_WIDTH-1:0] tile_q,  tile_d;
  logic [SEL_W-1:0]     sel_q,   sel_d;
  logic [FL_W-1:0]      flush_q, flush_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tile_d  = tile_q;
    sel_d   = sel_q;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          tile_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Counter advances only on accepted words; stalls hold everything.
        if (ifm_valid) begin
          if (acc_q == ACC_LAST) begin
            acc_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            acc_d = acc_q + CNT_WIDTH'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (acc_q == ACC_LAST) begin
          acc_d   = '0;
          flush_d = '0;
          state_d = S_FLUSH;
        end else begin
          acc_d = acc_q + CNT_WIDTH'(1);
        end
      end
      S_FLUSH: begin
        // Separate counter so acc_idx stays at 0 ready for the next tile.
        if (flush_q == FL_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      S_CAPTURE: begin
        sel_d   = '0;
        acc_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (sel_q == SEL_LAST) begin
            // Explicit wrap keeps non-power-of-two TILING_SIZE correct.
            sel_d = '0;
            if (tile_q == TILE_LAST) begin
              state_d = S_DONE;
            end else begin
              tile_d  = tile_q + CNT_WIDTH'(1);
              state_d = S_COMPUTE;
            end
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      tile_q  <= '0;
      sel_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tile_q  <= tile_d;
      sel_q   <= sel_d;
      flush_q <= flush_d;
    end
  end

  // Output decode. buf_wr_en and buf_wr_clr also look at the live inputs so
  // the accepted word and the pointer clear land in the same cycle.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign ifm_read   = (state_q == S_LOAD);
  assign buf_wr_en  = ifm_valid & (state_q == S_LOAD);
  assign buf_wr_clr = start & (state_q == S_IDLE);
  assign buf_rd_en  = (state_q == S_COMPUTE);
  assign wgt_read   = (state_q == S_COMPUTE);
  assign set_reg    = (state_q == S_COMPUTE);
  assign psum_clr   = (state_q == S_COMPUTE) & (acc_q == '0);
  assign set_output = (state_q == S_CAPTURE);
  assign buf_rd_clr = (state_q == S_CAPTURE);
  assign valid_data = (state_q == S_DRAIN);
  assign out_sel    = sel_q;
  assign tile_idx   = tile_q;
  assign acc_idx    = acc_q;

endmodule

// File: tb/tb_fc_tile_sequencer.sv
module tb_fc_tile_sequencer;

  localparam int unsigned IFM  = 4;
  localparam int unsigned KER  = 16;
  localparam int unsigned TIL  = 8;
  localparam int unsigned PL   = 1;
  localparam int unsigned CW   = 16;
  localparam int unsigned SW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done;
  logic          ifm_valid, ifm_read;
  logic          buf_wr_en, buf_rd_en, buf_wr_clr, buf_rd_clr;
  logic          wgt_read, set_reg, psum_clr, set_output;
  logic [SW-1:0] out_sel;
  logic          valid_data;
  logic          out_ready;
  logic [CW-1:0] tile_idx, acc_idx;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fc_tile_sequencer #(
    .IFM_SIZE   (IFM),
    .KERNEL_SIZE(KER),
    .TILING_SIZE(TIL),
    .PIPE_LAT   (PL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ifm_valid (ifm_valid),
    .ifm_read  (ifm_read),
    .buf_wr_en (buf_wr_en),
    .buf_rd_en (buf_rd_en),
    .buf_wr_clr(buf_wr_clr),
    .buf_rd_clr(buf_rd_clr),
    .wgt_read  (wgt_read),
    .set_reg   (set_reg),
    .psum_clr  (psum_clr),
    .set_output(set_output),
    .out_sel   (out_sel),
    .valid_data(valid_data),
    .out_ready (out_ready),
    .tile_idx  (tile_idx),
    .acc_idx   (acc_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // All outputs must be zero while reset is held.
  task automatic check_reset_outputs(input string pfx);
    check({pfx, " busy"},       32'(busy),       0);
    check({pfx, " done"},       32'(done),       0);
    check({pfx, " ifm_read"},   32'(ifm_read),   0);
    check({pfx, " buf_wr_en"},  32'(buf_wr_en),  0);
    check({pfx, " buf_rd_en"},  32'(buf_rd_en),  0);
    check({pfx, " buf_wr_clr"}, 32'(buf_wr_clr), 0);
    check({pfx, " buf_rd_clr"}, 32'(buf_rd_clr), 0);
    check({pfx, " wgt_read"},   32'(wgt_read),   0);
    check({pfx, " set_reg"},    32'(set_reg),    0);
    check({pfx, " psum_clr"},   32'(psum_clr),   0);
    check({pfx, " set_output"}, 32'(set_output), 0);
    check({pfx, " valid_data"}, 32'(valid_data), 0);
    check({pfx, " out_sel"},    32'(out_sel),    0);
    check({pfx, " tile_idx"},   32'(tile_idx),   0);
    check({pfx, " acc_idx"},    32'(acc_idx),    0);
  endtask

  // Scenarios: 0 basic, 1 IFM stalls, 2 backpressure, 3 start while busy.
  // abort_at >= 0 asserts reset mid-cycle at that cycle and returns.
  // Entered and left at posedge+1.
  task automatic run_job(input int sc, input int abort_at);
    int ld_end, c0, cap0, d0s, d0e, c1, cap1, d1s, d1e, dn;
    int xfers, dones;
    int e_busy, e_wr, e_cmp, e_drn, e_acc, e_sel, iv, ordy;
    string p;
    // Hand-derived timelines (cycle 0 = start cycle).
    case (sc)
      1:       begin ld_end=7; c0=8; cap0=13; d0s=14; d0e=21; c1=22; cap1=27; d1s=28; d1e=35; dn=36; end
      2:       begin ld_end=4; c0=5; cap0=10; d0s=11; d0e=21; c1=22; cap1=27; d1s=28; d1e=35; dn=36; end
      default: begin ld_end=4; c0=5; cap0=10; d0s=11; d0e=18; c1=19; cap1=24; d1s=25; d1e=32; dn=33; end
    endcase
    xfers = 0;
    dones = 0;
    for (int cyc = 0; cyc <= dn + 1; cyc++) begin
      iv   = (sc == 1) ? (cyc % 2) : 1;
      ordy = (sc == 2 && cyc >= 12 && cyc <= 14) ? 0 : 1;
      start     = (cyc == 0) || (sc == 3 && cyc == 7);
      ifm_valid = iv[0];
      out_ready = ordy[0];
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #2;
        check_reset_outputs($sformatf("sc%0d rst@%0d", sc, cyc));
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      p = $sformatf("sc%0d c%0d", sc, cyc);
      e_busy = (cyc >= 1 && cyc <= dn) ? 1 : 0;
      e_wr   = (cyc >= 1 && cyc <= ld_end) ? 1 : 0;
      e_cmp  = ((cyc >= c0 && cyc < c0 + 4) || (cyc >= c1 && cyc < c1 + 4)) ? 1 : 0;
      e_drn  = ((cyc >= d0s && cyc <= d0e) || (cyc >= d1s && cyc <= d1e)) ? 1 : 0;
      check({p, " busy"},       32'(busy),       e_busy);
      check({p, " done"},       32'(done),       (cyc == dn) ? 1 : 0);
      check({p, " ifm_read"},   32'(ifm_read),   e_wr);
      check({p, " buf_wr_en"},  32'(buf_wr_en),  (e_wr != 0 && iv != 0) ? 1 : 0);
      check({p, " buf_wr_clr"}, 32'(buf_wr_clr), (cyc == 0) ? 1 : 0);
      check({p, " buf_rd_en"},  32'(buf_rd_en),  e_cmp);
      check({p, " wgt_read"},   32'(wgt_read),   e_cmp);
      check({p, " set_reg"},    32'(set_reg),    e_cmp);
      check({p, " psum_clr"},   32'(psum_clr),   (cyc == c0 || cyc == c1) ? 1 : 0);
      check({p, " set_output"}, 32'(set_output), (cyc == cap0 || cyc == cap1) ? 1 : 0);
      check({p, " buf_rd_clr"}, 32'(buf_rd_clr), (cyc == cap0 || cyc == cap1) ? 1 : 0);
      check({p, " valid_data"}, 32'(valid_data), e_drn);
      if (cyc >= 1)
        check({p, " tile_idx"}, 32'(tile_idx), (cyc < c1) ? 0 : 1);
      if (e_wr != 0) begin
        e_acc = (sc == 1) ? cyc / 2 : cyc - 1;
        check({p, " acc_idx load"}, 32'(acc_idx), e_acc);
      end
      if (e_cmp != 0) begin
        e_acc = (cyc < c1) ? cyc - c0 : cyc - c1;
        check({p, " acc_idx comp"}, 32'(acc_idx), e_acc);
      end
      if (e_drn != 0) begin
        if (sc == 2 && cyc <= d0e)
          e_sel = (cyc == 11) ? 0 : ((cyc <= 14) ? 1 : cyc - 14);
        else
          e_sel = (cyc <= d0e) ? cyc - d0s : cyc - d1s;
        check({p, " out_sel"}, 32'(out_sel), e_sel);
      end
      if (valid_data && out_ready) begin
        check({p, " xfer order"}, 32'(out_sel), xfers % 8);
        xfers++;
      end
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check($sformatf("sc%0d transfers", sc), xfers, 16);
    check($sformatf("sc%0d done pulses", sc), dones, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    ifm_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job(0, -1);   // basic job
    run_job(1, -1);   // IFM stalls on alternate cycles
    run_job(2, -1);   // out_ready low cycles 12-14
    run_job(3, -1);   // second start at cycle 7 ignored
    run_job(0, 15);   // reset mid-DRAIN
    run_job(0, -1);   // fresh job after reset repeats basic timing

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
